// File: rtl/sseg_scan.sv
// sseg_scan: time-multiplexed scan controller for a 6-digit seven-segment display.
// Double-buffered frame, dead-time blank at every digit change, optional
// leading-zero suppression. digit/digit_pos/seg_en/frame_sync are registered.
//
// state | meaning
// BLANK | dead time at start of a slot, seg_en held low
// SHOW  | current position lit unless suppressed or invalid BCD
module sseg_scan #(
  parameter int DIV         = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [29:0] digits_in,
  output logic [4:0]  digit,
  output logic [2:0]  digit_pos,
  output logic        seg_en,
  output logic        frame_sync
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [29:0]   active, active_nxt, pending;
  logic          pending_valid;
  logic          slot_end, blank_end, wrap_edge;
  logic [2:0]    pos_nxt;
  logic [4:0]    act_ent [6];
  logic [4:0]    nxt_ent [6];
  logic [5:0]    lead_zero;
  logic          pos_ok;

  assign slot_end  = (cnt == CW'(DIV - 1));
  assign blank_end = (cnt == CW'(BLANK_CYC - 1));
  assign wrap_edge = slot_end && (digit_pos == 3'd5);
  assign pos_nxt   = (digit_pos == 3'd5) ? 3'd0 : digit_pos + 3'd1;

  // Slot counter: free-running 0..DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (slot_end) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BLANK;
    else state <= state_nxt;
  end

  // FSM next state: dark for the first BLANK_CYC cycles of each slot.
  always_comb begin
    state_nxt = state;
    case (state)
      BLANK: if (blank_end) state_nxt = SHOW;
      SHOW:  if (slot_end)  state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  // Frame to be active after this edge; a load on the wrap edge wins over pending.
  always_comb begin
    active_nxt = active;
    if (wrap_edge) begin
      if (load) active_nxt = digits_in;
      else if (pending_valid) active_nxt = pending;
    end
  end

  // Split buffers into per-position entries and find the leading-zero run.
  always_comb begin
    logic run;
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      act_ent[i]   = active[5*i +: 5];
      nxt_ent[i]   = active_nxt[5*i +: 5];
      run          = run && (act_ent[i] == 5'd0);
      lead_zero[i] = run;
    end
  end

  // Whether the current position may light during SHOW.
  always_comb begin
    pos_ok = (act_ent[digit_pos][3:0] <= 4'd9);
    if ((LZ_SUPPRESS != 0) && (digit_pos != 3'd5) && lead_zero[digit_pos]) pos_ok = 1'b0;
  end

  // Buffers: pending collects loads, active only changes on the frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      active <= active_nxt;
      if (wrap_edge) pending_valid <= 1'b0;
      else if (load) begin
        pending       <= digits_in;
        pending_valid <= 1'b1;
      end
    end
  end

  // Outputs: position/digit move only while dark; seg_en follows the FSM edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit      <= 5'd0;
      digit_pos  <= 3'd0;
      seg_en     <= 1'b0;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= 1'b0;
      if (state == SHOW && slot_end) begin
        digit_pos  <= pos_nxt;
        digit      <= nxt_ent[pos_nxt];
        seg_en     <= 1'b0;
        frame_sync <= wrap_edge;
      end else if (state == BLANK && blank_end) begin
        seg_en <= pos_ok;
      end
    end
  end

endmodule
